fmpadding_cfg_sequencer: RTL and testbench
==========================================

// Module: fmpadding_cfg_sequencer
// PURPOSE
//  Configuration controller for the AXI-lite parameter port of fmpadding_axi.
//  - Accepts one padding job per handshake: padded frame size plus four pad widths.
//  - Derives XOn/XOff/XEnd/YOn/YOff/YEnd and range-checks them.
//  - Issues the six AXI-lite register writes in order, then reports completion or error.
//  - Sits between the host/scheduler and fmpadding_axi.
// PARAMETERS
//  XCOUNTER_BITS  8  width of X size/pad fields; must match the padder's parameter
//  YCOUNTER_BITS  8  width of Y size/pad fields; must match the padder's parameter
// PORTS
//  ap_clk            in   1   clock
//  ap_rst_n          in   1   asynchronous, active-low reset
//  cfg_valid         in   1   job request
//  cfg_ready         out  1   job accepted when cfg_valid && cfg_ready
//  cfg_xsize         in   XCOUNTER_BITS  padded output width
//  cfg_pad_left      in   XCOUNTER_BITS  left padding
//  cfg_pad_right     in   XCOUNTER_BITS  right padding
//  cfg_ysize         in   YCOUNTER_BITS  padded output height
//  cfg_pad_top       in   YCOUNTER_BITS  top padding
//  cfg_pad_bottom    in   YCOUNTER_BITS  bottom padding
//  m_axilite_AWVALID out  1   write-address valid
//  m_axilite_AWREADY in   1   write-address ready
//  m_axilite_AWADDR  out  3   register index
//  m_axilite_WVALID  out  1   write-data valid
//  m_axilite_WREADY  in   1   write-data ready
//  m_axilite_WDATA   out  32  register value, zero-extended
//  m_axilite_WSTRB   out  4   constant 4'hF
//  m_axilite_BVALID  in   1   write response valid
//  m_axilite_BREADY  out  1   write response ready
//  m_axilite_BRESP   in   2   write response code
//  done_valid        out  1   one-cycle pulse at job end
//  done_err          out  2   00 ok, 01 geometry reject, 10 slave error; valid with done_valid
// BEHAVIOUR
//  - Reset (async assert, sync release) clears state to IDLE.
//    - Reset values: cfg_ready=1, AWVALID=WVALID=BREADY=0, done_valid=0, done_err=0.
//    - AWADDR and WDATA reset to 0.
//  - FSM states: IDLE -> CHECK -> AW -> W -> B -> (AW | DONE); CHECK -> DONE on reject.
//  - IDLE
//    - cfg_ready=1.
//    - On handshake, all cfg fields are registered; next state CHECK.
//    - cfg_ready=0 in all other states.
//  - CHECK (1 cycle)
//    - Reject (err 01) if pad_left+pad_right >= xsize, or pad_top+pad_bottom >= ysize.
//    - Sums are computed at width+1 bits; no wrap.
//    - xsize or ysize equal to 0 is also a reject.
//    - On reject, no AXI write is issued.
//  - Write table, idx 0..5:
//    - idx 0: addr 0, value pad_left (XOn)
//    - idx 1: addr 1, value xsize-pad_right (XOff)
//    - idx 2: addr 2, value xsize-1 (XEnd)
//    - idx 3: addr 4, value pad_top (YOn)
//    - idx 4: addr 5, value ysize-pad_bottom (YOff)
//    - idx 5: addr 6, value ysize-1 (YEnd)
//  - AW: AWVALID=1 with AWADDR held stable until AWREADY is sampled high.
//  - W:  WVALID=1 with WDATA held stable until WREADY is sampled high.
//    - AW and W are never asserted in the same cycle.
//  - B: BREADY=1 until BVALID.
//    - BRESP!=0: abort remaining writes, err 10.
//    - BRESP==0 and idx<5: idx++, go to AW.
//    - BRESP==0 and idx==5: err 00, go to DONE.
//  - DONE (1 cycle): done_valid=1 with done_err; next state IDLE.
//    - A new job may be accepted in the cycle after DONE.
//  - Latency with AXI slave always ready and BVALID one cycle after W:
//    - Accept at cycle 0; first AWVALID at cycle 2.
//    - Each write takes 3 cycles (AW, W, B).
//    - done_valid at cycle 20.
//  - cfg_* changes while busy are ignored; the registered copy is used.
//  - Reset mid-job
//    - AWVALID/WVALID drop immediately and no done_valid is produced.
//    - The padder must be reset with it so its registers do not hold a half-written config.
// TESTING
//  - Nominal: xsize=10, ysize=7, pads L2 R3 T1 B2.
//    -> writes (0,2)(1,7)(2,9)(4,1)(5,5)(6,6) in order; done_err=00 at cycle 20.
//  - Slave backpressure: AWREADY/WREADY/BVALID randomly delayed 0..4 cycles.
//    -> same six writes; AWADDR/WDATA stable while VALID && !READY; no VALID retraction.
//  - Geometry reject: xsize=8, L4 R4.
//    -> no AWVALID ever; done_valid with done_err=01 at cycle 2.
//  - Slave error: BRESP=2'b10 on the 3rd write.
//    -> exactly 3 AW/W pairs; done_err=10; cfg_ready=1 the following cycle.
//  - Reset mid-job: ap_rst_n low while WVALID=1 on the 4th write.
//    -> all outputs at reset values within the same cycle; next job completes cleanly with 00.
//  - Back-to-back: cfg_valid held high with a second job.
//    -> cfg_ready=0 until after DONE; second job accepted exactly one cycle after done_valid.

Source files
------------

// File: rtl/fmpadding_cfg_sequencer.sv
// fmpadding_cfg_sequencer: range-checks one padding job and writes its six geometry registers over AXI-lite
module fmpadding_cfg_sequencer #(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [XCOUNTER_BITS-1:0] cfg_xsize,
  input  logic [XCOUNTER_BITS-1:0] cfg_pad_left,
  input  logic [XCOUNTER_BITS-1:0] cfg_pad_right,
  input  logic [YCOUNTER_BITS-1:0] cfg_ysize,
  input  logic [YCOUNTER_BITS-1:0] cfg_pad_top,
  input  logic [YCOUNTER_BITS-1:0] cfg_pad_bottom,
  output logic                     m_axilite_AWVALID,
  input  logic                     m_axilite_AWREADY,
  output logic [2:0]               m_axilite_AWADDR,
  output logic                     m_axilite_WVALID,
  input  logic                     m_axilite_WREADY,
  output logic [31:0]              m_axilite_WDATA,
  output logic [3:0]               m_axilite_WSTRB,
  input  logic                     m_axilite_BVALID,
  output logic                     m_axilite_BREADY,
  input  logic [1:0]               m_axilite_BRESP,
  output logic                     done_valid,
  output logic [1:0]               done_err
);
  typedef enum logic [2:0] {IDLE, CHECK, AW, W, B, DONE} state_t;
  state_t state, state_d;
  logic [XCOUNTER_BITS-1:0] xsize, pad_left, pad_right, xoff;
  logic [YCOUNTER_BITS-1:0] ysize, pad_top, pad_bottom, yoff;
  logic [2:0] idx;
  logic [1:0] err;
  logic reject;
  // one extra bit keeps the pad sums from wrapping; a zero size fails the same test
  assign reject = ({1'b0, pad_left} + {1'b0, pad_right} >= {1'b0, xsize}) ||
                  ({1'b0, pad_top} + {1'b0, pad_bottom} >= {1'b0, ysize});
  assign xoff = xsize - pad_right;
  assign yoff = ysize - pad_bottom;
  assign cfg_ready = state == IDLE;
  assign m_axilite_AWVALID = state == AW;
  assign m_axilite_WVALID = state == W;
  assign m_axilite_BREADY = state == B;
  assign m_axilite_WSTRB = 4'hF;
  assign m_axilite_AWADDR = idx < 3'd3 ? idx : idx + 3'd1;
  assign done_valid = state == DONE;
  assign done_err = err;
  always_comb begin
    m_axilite_WDATA = idx == 3'd0 ? 32'(pad_left) :
                      idx == 3'd1 ? 32'(xoff) :
                      idx == 3'd2 ? 32'(xsize - 1'b1) :
                      idx == 3'd3 ? 32'(pad_top) :
                      idx == 3'd4 ? 32'(yoff) :
                      idx == 3'd5 ? 32'(ysize - 1'b1) : 32'd0;
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (cfg_valid) state_d = CHECK;
      CHECK:   state_d = reject ? DONE : AW;
      AW:      if (m_axilite_AWREADY) state_d = W;
      W:       if (m_axilite_WREADY) state_d = B;
      B:       if (m_axilite_BVALID) state_d = (m_axilite_BRESP != 2'b00 || idx == 3'd5) ? DONE : AW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      idx <= '0;
      err <= '0;
      xsize <= '0;
      pad_left <= '0;
      pad_right <= '0;
      ysize <= '0;
      pad_top <= '0;
      pad_bottom <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && cfg_valid) begin
        xsize <= cfg_xsize;
        pad_left <= cfg_pad_left;
        pad_right <= cfg_pad_right;
        ysize <= cfg_ysize;
        pad_top <= cfg_pad_top;
        pad_bottom <= cfg_pad_bottom;
      end
      if (state == CHECK) begin
        idx <= '0;
        err <= reject ? 2'b01 : 2'b00;
      end
      if (state == B && m_axilite_BVALID) begin
        if (m_axilite_BRESP != 2'b00) err <= 2'b10;
        else idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_fmpadding_cfg_sequencer.sv
// tb_fmpadding_cfg_sequencer: randomized and directed jobs against a table-driven write model
module tb_fmpadding_cfg_sequencer;
  logic ap_clk = 0, ap_rst_n = 0;
  logic cfg_valid = 0, cfg_ready;
  logic [7:0] cfg_xsize = 0, cfg_pad_left = 0, cfg_pad_right = 0;
  logic [7:0] cfg_ysize = 0, cfg_pad_top = 0, cfg_pad_bottom = 0;
  logic awvalid, awready, wvalid, wready, bvalid, bready, done_valid;
  logic [2:0] awaddr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, done_err;
  int total = 0, bad = 0, cyc = 0;
  bit bp = 0;
  int err_at = 0;
  int acc_q[$], done_q[$], aw_q[$], w_q[$], exp_aw[$], exp_w[$];
  logic [1:0] derr_q[$];

  fmpadding_cfg_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_xsize(cfg_xsize), .cfg_pad_left(cfg_pad_left), .cfg_pad_right(cfg_pad_right),
    .cfg_ysize(cfg_ysize), .cfg_pad_top(cfg_pad_top), .cfg_pad_bottom(cfg_pad_bottom),
    .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
    .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(wdata),
    .m_axilite_WSTRB(wstrb), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(bready),
    .m_axilite_BRESP(bresp), .done_valid(done_valid), .done_err(done_err));

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic drive();
    @(posedge ap_clk);
    #1;
  endtask

  // expected write sequence straight from the geometry rules
  function automatic void model(input int xs, l, r, ys, t, b, ea, output logic [1:0] err, output int lat);
    int a[6];
    int v[6];
    a = '{0, 1, 2, 4, 5, 6};
    v = '{l, xs - r, xs - 1, t, ys - b, ys - 1};
    if (xs == 0 || ys == 0 || l + r >= xs || t + b >= ys) begin
      err = 2'b01;
      lat = 2;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      exp_aw.push_back(a[i]);
      exp_w.push_back(v[i]);
      if (ea == i + 1) begin
        err = 2'b10;
        lat = 2 + 3 * (i + 1);
        return;
      end
    end
    err = 2'b00;
    lat = 20;
  endfunction

  task automatic clear_q();
    acc_q.delete(); done_q.delete(); aw_q.delete(); w_q.delete();
    exp_aw.delete(); exp_w.delete(); derr_q.delete();
  endtask

  task automatic set_cfg(input int xs, l, r, ys, t, b);
    cfg_xsize = 8'(xs); cfg_pad_left = 8'(l); cfg_pad_right = 8'(r);
    cfg_ysize = 8'(ys); cfg_pad_top = 8'(t); cfg_pad_bottom = 8'(b);
  endtask

  task automatic wait_acc(input int n);
    int lim = 0;
    while (acc_q.size() < n && lim < 200) begin tick(); lim++; end
    chk("accept_seen", 64'(acc_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int n);
    int lim = 0;
    while (done_q.size() < n && lim < 2000) begin tick(); lim++; end
    chk("done_seen", 64'(done_q.size() >= n), 1);
  endtask

  task automatic cmp_writes();
    chk("n_aw", aw_q.size(), exp_aw.size());
    chk("n_w", w_q.size(), exp_w.size());
    for (int i = 0; i < exp_aw.size() && i < aw_q.size() && i < w_q.size(); i++) begin
      chk($sformatf("awaddr[%0d]", i), aw_q[i], exp_aw[i]);
      chk($sformatf("wdata[%0d]", i), w_q[i], exp_w[i]);
    end
  endtask

  task automatic run_job(input int xs, l, r, ys, t, b, input bit bp_i, input int ea);
    logic [1:0] e;
    int lat;
    clear_q();
    bp = bp_i;
    err_at = ea;
    model(xs, l, r, ys, t, b, ea, e, lat);
    drive();
    set_cfg(xs, l, r, ys, t, b);
    cfg_valid = 1;
    wait_acc(1);
    drive();
    cfg_valid = 0;
    set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_done(1);
    if (done_q.size() == 1 && acc_q.size() == 1) begin
      chk("done_err", derr_q[0], e);
      if (!bp_i) chk("latency", done_q[0] - acc_q[0], lat);
    end
    cmp_writes();
    tick();
    chk("ready_after_done", cfg_ready, 1);
  endtask

  // AXI-lite slave with optional random stalls and an injectable error response
  initial begin
    int aw_d = -1, w_d = -1, b_d = -1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      drive();
      if (awvalid) begin
        if (aw_d < 0) aw_d = bp ? int'($urandom_range(0, 4)) : 0;
        awready = aw_d == 0;
        if (aw_d > 0) aw_d--;
      end else begin awready = 0; aw_d = -1; end
      if (wvalid) begin
        if (w_d < 0) w_d = bp ? int'($urandom_range(0, 4)) : 0;
        wready = w_d == 0;
        if (w_d > 0) w_d--;
      end else begin wready = 0; w_d = -1; end
      if (bready) begin
        if (b_d < 0) b_d = bp ? int'($urandom_range(0, 4)) : 0;
        bvalid = b_d == 0;
        if (b_d > 0) b_d--;
      end else begin bvalid = 0; b_d = -1; end
      bresp = (bvalid && w_q.size() == err_at) ? 2'b10 : 2'b00;
    end
  end

  // protocol monitor: records handshakes and checks hold/exclusion rules every cycle
  initial begin
    bit aw_hold = 0, w_hold = 0, busy = 0;
    logic [2:0] aw_prev = 0;
    logic [31:0] w_prev = 0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        aw_hold = 0; w_hold = 0; busy = 0;
      end else begin
        if (busy) chk("ready_busy", cfg_ready, 0);
        if (aw_hold) begin chk("aw_hold", awvalid, 1); chk("aw_stable", awaddr, aw_prev); end
        if (w_hold) begin chk("w_hold", wvalid, 1); chk("w_stable", wdata, w_prev); end
        if (awvalid || wvalid) chk("aw_w_excl", 64'(awvalid && wvalid), 0);
        if (wvalid) chk("wstrb", wstrb, 4'hF);
        if (awvalid && awready) aw_q.push_back(int'(awaddr));
        if (wvalid && wready) w_q.push_back(int'(wdata));
        if (done_valid) begin done_q.push_back(cyc); derr_q.push_back(done_err); busy = 0; end
        if (cfg_valid && cfg_ready) begin acc_q.push_back(cyc); busy = 1; end
        aw_hold = awvalid && !awready; aw_prev = awaddr;
        w_hold = wvalid && !wready; w_prev = wdata;
      end
    end
  end

  initial begin
    int lim;
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    #11 ap_rst_n = 1;
    run_job(10, 2, 3, 7, 1, 2, 0, 0);
    run_job(10, 2, 3, 7, 1, 2, 1, 0);
    run_job(8, 4, 4, 7, 1, 2, 0, 0);
    run_job(10, 2, 3, 7, 1, 2, 0, 3);
    run_job(0, 0, 0, 5, 1, 1, 0, 0);
    run_job(5, 1, 1, 0, 0, 0, 0, 0);
    run_job(255, 127, 127, 255, 0, 254, 0, 0);
    run_job(255, 128, 127, 9, 1, 1, 0, 0);
    run_job(200, 200, 200, 9, 1, 1, 0, 0);
    run_job(9, 1, 1, 200, 150, 150, 0, 0);
    run_job(1, 0, 0, 1, 0, 0, 0, 6);
    // reset while the fourth write's data phase is on the bus
    clear_q();
    bp = 0; err_at = 0;
    drive();
    set_cfg(10, 2, 3, 7, 1, 2);
    cfg_valid = 1;
    wait_acc(1);
    drive();
    cfg_valid = 0;
    lim = 0;
    while (!(wvalid && w_q.size() == 3) && lim < 100) begin tick(); lim++; end
    chk("reached_w4", 64'(wvalid && w_q.size() == 3), 1);
    ap_rst_n = 0;
    #1;
    chk("midrst_awvalid", awvalid, 0);
    chk("midrst_wvalid", wvalid, 0);
    chk("midrst_bready", bready, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_done_valid", done_valid, 0);
    chk("midrst_done_err", done_err, 0);
    chk("midrst_awaddr", awaddr, 0);
    chk("midrst_wdata", wdata, 0);
    tick(); tick();
    ap_rst_n = 1;
    tick(); tick(); tick();
    chk("midrst_no_done", done_q.size(), 0);
    run_job(10, 2, 3, 7, 1, 2, 0, 0);
    // back-to-back: cfg_valid stays high across both jobs
    clear_q();
    bp = 0; err_at = 0;
    begin
      logic [1:0] e1, e2;
      int l1, l2;
      model(10, 2, 3, 7, 1, 2, 0, e1, l1);
      model(20, 5, 6, 12, 3, 4, 0, e2, l2);
      drive();
      set_cfg(10, 2, 3, 7, 1, 2);
      cfg_valid = 1;
      wait_acc(1);
      drive();
      set_cfg(20, 5, 6, 12, 3, 4);
      wait_acc(2);
      drive();
      cfg_valid = 0;
      wait_done(2);
      if (done_q.size() == 2 && acc_q.size() == 2) begin
        chk("b2b_gap", acc_q[1] - done_q[0], 1);
        chk("b2b_err0", derr_q[0], e1);
        chk("b2b_err1", derr_q[1], e2);
        chk("b2b_lat1", done_q[1] - acc_q[1], l2);
      end
      cmp_writes();
    end
    for (int k = 0; k < 25; k++)
      run_job($urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 12),
              $urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 12),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 6)) : 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
